regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 11 +
 rtl/regfile_wb_arbiter_if.sv | 27 ++
 rtl/regfile_wb_arbiter_rr_arb2.sv | 29 ++
 rtl/regfile_wb_arbiter.sv | 104 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and FSM state type for the register-file writeback arbiter.
package regfile_pkg;
  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } wb_state_e;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: two requesters (A = ALU, B = load unit) and the single register file write port.
interface regfile_wb_arbiter_if #(
  parameter int XLEN = regfile_pkg::XLEN
);
  logic                              i_a_valid;
  logic [regfile_pkg::REG_ADDR_W-1:0] i_a_rd;
  logic [XLEN-1:0]                   i_a_data;
  logic                              o_a_ready;
  logic                              i_b_valid;
  logic [regfile_pkg::REG_ADDR_W-1:0] i_b_rd;
  logic [XLEN-1:0]                   i_b_data;
  logic                              o_b_ready;
  logic                              o_we;
  logic [regfile_pkg::REG_ADDR_W-1:0] o_rd;
  logic [XLEN-1:0]                   o_data;
  logic                              o_init_done;

  modport master (
    output i_a_valid, i_a_rd, i_a_data, i_b_valid, i_b_rd, i_b_data,
    input  o_a_ready, o_b_ready, o_we, o_rd, o_data, o_init_done
  );

  modport slave (
    input  i_a_valid, i_a_rd, i_a_data, i_b_valid, i_b_rd, i_b_data,
    output o_a_ready, o_b_ready, o_we, o_rd, o_data, o_init_done
  );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the last-grant pointer moves only when a grant is taken.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  logic last_b_reg;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_b_reg ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer starts on B so that A wins the first tie.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      last_b_reg <= 1'b1;
    end else if (advance) begin
      last_b_reg <= gnt[1];
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: clears x1..x31 after reset, then merges two writeback streams onto one write port.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int XLEN       = regfile_pkg::XLEN,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_resetn,
  regfile_wb_arbiter_if.slave  bus
);
  localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);

  wb_state_e             state_reg, state_next;
  logic [REG_ADDR_W-1:0] idx_reg, idx_next;
  logic                  we_reg, we_next;
  logic [REG_ADDR_W-1:0] rd_reg, rd_next;
  logic [XLEN-1:0]       data_reg, data_next;
  logic                  init_done_reg, init_done_next;

  logic       run;
  logic [1:0] req;
  logic [1:0] gnt;

  // Requests are masked outside RUN and during reset so no grant can leak out.
  assign run = (state_reg == RUN) && i_resetn;
  assign req = {bus.i_b_valid & run, bus.i_a_valid & run};

  rr_arb2 u_arb (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .req      (req),
    .advance  (|gnt),
    .gnt      (gnt)
  );

  assign bus.o_a_ready   = gnt[0];
  assign bus.o_b_ready   = gnt[1];
  assign bus.o_we        = we_reg;
  assign bus.o_rd        = rd_reg;
  assign bus.o_data      = data_reg;
  assign bus.o_init_done = init_done_reg;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      state_reg     <= INIT;
      idx_reg       <= REG_ADDR_W'(1);
      we_reg        <= 1'b0;
      rd_reg        <= '0;
      data_reg      <= '0;
      init_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      we_reg        <= we_next;
      rd_reg        <= rd_next;
      data_reg      <= data_next;
      init_done_reg <= init_done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      INIT:    if (!INIT_CLEAR || idx_reg == LAST_IDX) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  always_comb begin
    idx_next       = idx_reg;
    we_next        = 1'b0;
    rd_next        = rd_reg;
    data_next      = data_reg;
    init_done_next = init_done_reg;
    case (state_reg)
      INIT: begin
        if (INIT_CLEAR) begin
          we_next        = 1'b1;
          rd_next        = idx_reg;
          data_next      = '0;
          idx_next       = idx_reg + REG_ADDR_W'(1);
          init_done_next = (idx_reg == LAST_IDX);
        end else begin
          init_done_next = 1'b1;
        end
      end
      RUN: begin
        // x0 is hardwired: the transfer still happens, only the strobe is suppressed.
        if (gnt[0]) begin
          we_next   = (bus.i_a_rd != '0);
          rd_next   = bus.i_a_rd;
          data_next = bus.i_a_data;
        end else if (gnt[1]) begin
          we_next   = (bus.i_b_rd != '0);
          rd_next   = bus.i_b_rd;
          data_next = bus.i_b_data;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: init sweep, reset restart, arbitration table, no-clear variant.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.XLEN(64)) bus1 ();
  regfile_wb_arbiter_if #(.XLEN(64)) bus2 ();

  regfile_wb_arbiter #(.XLEN(64), .INIT_CLEAR(1'b1)) dut (
    .i_clk    (clk),
    .i_resetn (resetn),
    .bus      (bus1.slave)
  );

  regfile_wb_arbiter #(.XLEN(64), .INIT_CLEAR(1'b0)) dut_nc (
    .i_clk    (clk),
    .i_resetn (resetn),
    .bus      (bus2.slave)
  );

  typedef struct {
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [63:0] a_data;
    logic        b_valid;
    logic [4:0]  b_rd;
    logic [63:0] b_data;
    logic        exp_a_ready;
    logic        exp_b_ready;
    logic        exp_we;
    logic        chk_rd_data;
    logic [4:0]  exp_rd;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    bus1.i_a_valid = v.a_valid;
    bus1.i_a_rd    = v.a_rd;
    bus1.i_a_data  = v.a_data;
    bus1.i_b_valid = v.b_valid;
    bus1.i_b_rd    = v.b_rd;
    bus1.i_b_data  = v.b_data;
  endtask

  initial begin
    logic [63:0] last7;
    last7 = '0;

    // Pointer is B after init: A, B, A, B, then single-requester and tie cases.
    vecs[0]  = '{1'b1, 5'd5, 64'hAA, 1'b1, 5'd6, 64'hBB, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 64'hAA};
    vecs[1]  = '{1'b1, 5'd5, 64'hA1, 1'b1, 5'd6, 64'hB1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd6, 64'hB1};
    vecs[2]  = '{1'b1, 5'd5, 64'hA2, 1'b1, 5'd6, 64'hB2, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 64'hA2};
    vecs[3]  = '{1'b1, 5'd5, 64'hA3, 1'b1, 5'd6, 64'hB3, 1'b0, 1'b1, 1'b1, 1'b1, 5'd6, 64'hB3};
    vecs[4]  = '{1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 64'hB3};
    vecs[5]  = '{1'b0, 5'd0, 64'h0,  1'b1, 5'd0, 64'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0};
    vecs[6]  = '{1'b1, 5'd7, 64'h11, 1'b1, 5'd7, 64'h22, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 64'h11};
    vecs[7]  = '{1'b0, 5'd0, 64'h0,  1'b1, 5'd7, 64'h22, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 64'h22};
    vecs[8]  = '{1'b1, 5'd9, 64'h99, 1'b0, 5'd0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 64'h99};
    vecs[9]  = '{1'b1, 5'd10, 64'hA10, 1'b1, 5'd11, 64'hB11, 1'b0, 1'b1, 1'b1, 1'b1, 5'd11, 64'hB11};
    vecs[10] = '{1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  1'b0, 1'b0, 1'b0, 1'b1, 5'd11, 64'hB11};

    bus1.i_a_valid = 1'b1; bus1.i_a_rd = 5'd3; bus1.i_a_data = 64'h33;
    bus1.i_b_valid = 1'b0; bus1.i_b_rd = 5'd0; bus1.i_b_data = 64'h0;
    bus2.i_a_valid = 1'b1; bus2.i_a_rd = 5'd2; bus2.i_a_data = 64'h22;
    bus2.i_b_valid = 1'b0; bus2.i_b_rd = 5'd0; bus2.i_b_data = 64'h0;

    resetn = 1'b0;
    repeat (3) tick();
    chk("rst_we", 64'(bus1.o_we), 64'd0);
    chk("rst_rd", 64'(bus1.o_rd), 64'd0);
    chk("rst_data", bus1.o_data, 64'd0);
    chk("rst_init_done", 64'(bus1.o_init_done), 64'd0);
    chk("rst_a_ready", 64'(bus1.o_a_ready), 64'd0);
    chk("rst_nc_init_done", 64'(bus2.o_init_done), 64'd0);

    resetn = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 1) begin
        chk("nc_init_done", 64'(bus2.o_init_done), 64'd1);
        chk("nc_a_ready", 64'(bus2.o_a_ready), 64'd1);
        chk("nc_we", 64'(bus2.o_we), 64'd0);
      end
      $display("init1 edge %0d: we=%0b rd=%0d", k, bus1.o_we, bus1.o_rd);
      chk("init1_we", 64'(bus1.o_we), 64'd1);
      chk("init1_rd", 64'(bus1.o_rd), 64'(k));
      chk("init1_a_ready", 64'(bus1.o_a_ready), 64'd0);
    end

    resetn = 1'b0;
    tick();
    chk("midinit_rst_we", 64'(bus1.o_we), 64'd0);
    chk("midinit_rst_rd", 64'(bus1.o_rd), 64'd0);
    resetn = 1'b1;

    for (int k = 1; k <= 31; k++) begin
      tick();
      $display("init2 edge %0d: we=%0b rd=%0d data=%0h done=%0b", k, bus1.o_we, bus1.o_rd,
               bus1.o_data, bus1.o_init_done);
      chk("init2_we", 64'(bus1.o_we), 64'd1);
      chk("init2_rd", 64'(bus1.o_rd), 64'(k));
      chk("init2_data", bus1.o_data, 64'd0);
      chk("init2_done", 64'(bus1.o_init_done), 64'(k == 31));
      if (k < 31) chk("init2_a_ready", 64'(bus1.o_a_ready), 64'd0);
      if (k == 30) bus1.i_a_valid = 1'b0;
    end

    tick();
    chk("run_idle_we", 64'(bus1.o_we), 64'd0);

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i]);
      #1;
      chk("vec_a_ready", 64'(bus1.o_a_ready), 64'(vecs[i].exp_a_ready));
      chk("vec_b_ready", 64'(bus1.o_b_ready), 64'(vecs[i].exp_b_ready));
      tick();
      $display("vec %0d: a_rdy=%0b b_rdy=%0b -> we=%0b rd=%0d data=%0h", i,
               vecs[i].exp_a_ready, vecs[i].exp_b_ready, bus1.o_we, bus1.o_rd, bus1.o_data);
      chk("vec_we", 64'(bus1.o_we), 64'(vecs[i].exp_we));
      if (vecs[i].chk_rd_data) begin
        chk("vec_rd", 64'(bus1.o_rd), 64'(vecs[i].exp_rd));
        chk("vec_data", bus1.o_data, vecs[i].exp_data);
      end
      if (bus1.o_we && bus1.o_rd == 5'd7) last7 = bus1.o_data;
    end
    chk("same_rd_final", last7, 64'h22);

    // Reset landing right after a transfer must drop the pending write.
    bus1.i_a_valid = 1'b1; bus1.i_a_rd = 5'd4; bus1.i_a_data = 64'h44;
    tick();
    $display("pre-reset transfer: we=%0b rd=%0d", bus1.o_we, bus1.o_rd);
    chk("prerst_we", 64'(bus1.o_we), 64'd1);
    chk("prerst_rd", 64'(bus1.o_rd), 64'd4);
    resetn = 1'b0;
    #1;
    chk("inrst_a_ready", 64'(bus1.o_a_ready), 64'd0);
    tick();
    $display("run reset: we=%0b done=%0b", bus1.o_we, bus1.o_init_done);
    chk("runrst_we", 64'(bus1.o_we), 64'd0);
    chk("runrst_done", 64'(bus1.o_init_done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
